// File: rtl/mini_soc_sched.sv
// Round-robin scheduler sharing the mini_soc ALU/MUX select inputs between NUM_REQ requesters.
// Each grant latches the winner's selects, holds them for EXEC_CYCLES, then returns soc_out.
module mini_soc_sched #(
  parameter int NUM_REQ     = 4,
  parameter int EXEC_CYCLES = 2,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = (EXEC_CYCLES > 0) ? $clog2(EXEC_CYCLES + 1) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] req_alu_sel_i,
  input  logic [NUM_REQ-1:0] req_mux_sel_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               alu_sel_o,
  output logic               mux_sel_o,
  input  logic [1:0]         soc_out_i,
  output logic               rsp_valid_o,
  output logic [ID_W-1:0]    rsp_id_o,
  output logic [1:0]         rsp_data_o,
  output logic               busy_o
);

  // state | meaning
  // IDLE  | no transaction, arbitrating every cycle
  // SETUP | selects driven and stable for one cycle
  // EXEC  | selects held while mini_soc settles, count runs
  // DONE  | rsp_valid pulse, arbitrate for next transaction
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               alu_sel_q;
  logic               mux_sel_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [1:0]         rsp_data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ID_W-1:0]    last_q;

  logic               win_vld_d;
  logic [ID_W-1:0]    win_id_d;
  logic               exec_last;

  // Rotating-priority search starting just after the previous winner.
  always_comb begin
    int unsigned idx;
    win_vld_d = 1'b0;
    win_id_d  = last_q;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!win_vld_d && req_i[idx]) begin
        win_vld_d = 1'b1;
        win_id_d  = ID_W'(idx);
      end
    end
  end

  assign exec_last = (cnt_q == CNT_W'(EXEC_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      alu_sel_q   <= 1'b0;
      mux_sel_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (win_vld_d) begin
            state_q   <= SETUP;
            gnt_q     <= NUM_REQ'(1) << win_id_d;
            alu_sel_q <= req_alu_sel_i[win_id_d];
            mux_sel_q <= req_mux_sel_i[win_id_d];
            last_q    <= win_id_d;
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          cnt_q   <= '0;
          state_q <= EXEC;
        end
        EXEC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (exec_last) begin
            rsp_data_q  <= soc_out_i;
            rsp_id_q    <= last_q;
            rsp_valid_q <= 1'b1;
            gnt_q       <= '0;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign alu_sel_o   = alu_sel_q;
  assign mux_sel_o   = mux_sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q != IDLE);

endmodule
